// File: rtl/net_node_if.sv
// Node-side network interface: queues CPU sends into 17-bit flits for the
// router injection port and buffers router deliveries for the CPU.
module net_node_if #(
    parameter int         TX_DEPTH = 4,
    parameter int         RX_DEPTH = 4,
    parameter logic [3:0] NODE_ID  = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_req,
    input  logic [3:0]  tx_dst,
    input  logic [7:0]  tx_data,
    output logic        tx_rdy,
    output logic [16:0] flit_out,
    input  logic        flit_ack,
    input  logic [8:0]  dlv_in,
    input  logic        rx_pop,
    output logic [7:0]  rx_data,
    output logic        rx_vld,
    output logic        rx_ovf
);

    // state | meaning
    // IDLE  | no flit on the injection port; load the TX FIFO head when present
    // SEND  | flit_out valid and held until the router acks it

    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);

    typedef enum logic {IDLE, SEND} tx_state_t;

    tx_state_t      tx_state;
    logic [15:0]    tx_mem [TX_DEPTH];
    logic [TXW-1:0] tx_wr_ptr;
    logic [TXW-1:0] tx_rd_ptr;
    logic [TXW:0]   tx_cnt;
    logic           tx_push;
    logic           tx_pop;

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RXW-1:0] rx_wr_ptr;
    logic [RXW-1:0] rx_rd_ptr;
    logic [RXW:0]   rx_cnt;
    logic           rx_full;
    logic           rx_push;
    logic           rx_take;

    // TX handshake: readiness comes from the count before the edge, so a full
    // FIFO refuses a push even while the FSM drains it.
    assign tx_rdy  = (tx_cnt != (TXW+1)'(TX_DEPTH));
    assign tx_push = tx_req & tx_rdy;
    assign tx_pop  = (tx_state == IDLE) && (tx_cnt != '0);

    // TX storage is a plain register array; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= {tx_dst, NODE_ID, tx_data};
    end

    // TX pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TXW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TXW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // Injection FSM: the ack edge only clears the flit, so the next load
    // happens one cycle later (at most one flit every two cycles).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            flit_out <= '0;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (tx_cnt != '0) begin
                        flit_out <= {1'b1, tx_mem[tx_rd_ptr]};
                        tx_state <= SEND;
                    end
                end
                SEND: begin
                    if (flit_ack) begin
                        flit_out <= '0;
                        tx_state <= IDLE;
                    end
                end
                default: begin
                    flit_out <= '0;
                    tx_state <= IDLE;
                end
            endcase
        end
    end

    // RX side: a pop in the same cycle frees the slot for a delivery into a
    // full FIFO, so only an un-popped full FIFO drops the word.
    assign rx_vld  = (rx_cnt != '0);
    assign rx_full = (rx_cnt == (RXW+1)'(RX_DEPTH));
    assign rx_take = rx_pop & rx_vld;
    assign rx_push = dlv_in[8] & (~rx_full | rx_take);
    assign rx_data = rx_vld ? rx_mem[rx_rd_ptr] : 8'h00;

    // RX storage.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= dlv_in[7:0];
    end

    // RX pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
            rx_ovf    <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RXW'(1);
            if (rx_take) rx_rd_ptr <= rx_rd_ptr + RXW'(1);
            case ({rx_push, rx_take})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
            if (dlv_in[8] && rx_full && !rx_take) rx_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_net_node_if.sv
// Self-checking bench for net_node_if: vector table, hand sequences for the
// multi-cycle corners and a random run against a queue-based model.
module tb_net_node_if;

    localparam int TXD = 4;
    localparam int RXD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_req = 1'b0;
    logic [3:0]  tx_dst = '0;
    logic [7:0]  tx_data = '0;
    logic        tx_rdy;
    logic [16:0] flit_out;
    logic        flit_ack = 1'b0;
    logic [8:0]  dlv_in = '0;
    logic        rx_pop = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        rx_ovf;

    net_node_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .NODE_ID(4'd2)) dut (
        .clk(clk), .rst(rst),
        .tx_req(tx_req), .tx_dst(tx_dst), .tx_data(tx_data), .tx_rdy(tx_rdy),
        .flit_out(flit_out), .flit_ack(flit_ack),
        .dlv_in(dlv_in), .rx_pop(rx_pop),
        .rx_data(rx_data), .rx_vld(rx_vld), .rx_ovf(rx_ovf)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the queues hold what the spec says is buffered, m_flit
    // is what sits on the injection port.
    logic [15:0] tx_q[$];
    logic [7:0]  rx_q[$];
    logic [16:0] m_flit;
    logic        m_ovf;

    typedef struct {
        logic        req;
        logic [3:0]  dst;
        logic [7:0]  data;
        logic        ack;
        logic [8:0]  dlv;
        logic        pop;
        logic [16:0] e_flit;
        logic        e_rdy;
        logic        e_vld;
        logic [7:0]  e_rxd;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        tx_q.delete();
        rx_q.delete();
        m_flit = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge();
        int  tx_pre;
        int  rx_pre;
        logic took;
        tx_pre = tx_q.size();
        if (m_flit[16]) begin
            if (flit_ack) m_flit = '0;
        end else if (tx_pre > 0) begin
            m_flit = {1'b1, tx_q.pop_front()};
        end
        if (tx_req && tx_pre < TXD) tx_q.push_back({tx_dst, 4'd2, tx_data});
        rx_pre = rx_q.size();
        took   = rx_pop && (rx_pre > 0);
        if (took) void'(rx_q.pop_front());
        if (dlv_in[8]) begin
            if (rx_pre < RXD || took) rx_q.push_back(dlv_in[7:0]);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_model();
        chk("mdl_flit", flit_out, m_flit);
        chk("mdl_tx_rdy", tx_rdy, tx_q.size() < TXD);
        chk("mdl_rx_vld", rx_vld, rx_q.size() > 0);
        chk("mdl_rx_data", rx_data, (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        chk("mdl_rx_ovf", rx_ovf, m_ovf);
    endtask

    // One clock: drive, edge, advance model, compare just after the edge.
    task automatic step(input logic req, input logic [3:0] dst, input logic [7:0] data,
                        input logic ack, input logic [8:0] dlv, input logic pop);
        tx_req = req; tx_dst = dst; tx_data = data;
        flit_ack = ack; dlv_in = dlv; rx_pop = pop;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        tx_req = 1'b0; flit_ack = 1'b0; dlv_in = '0; rx_pop = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    logic [7:0] got[$];

    initial begin
        vecs[0]  = '{1'b1, 4'h5, 8'hA7, 1'b0, 9'h000, 1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b0, 17'h152A7, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b0, 17'h152A7, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b0, 17'h152A7, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 8'h00, 1'b1, 9'h000, 1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 8'h00, 1'b0, 9'h111, 1'b0, 17'h00000, 1'b1, 1'b1, 8'h11, 1'b0};
        vecs[7]  = '{1'b0, 4'h0, 8'h00, 1'b0, 9'h122, 1'b0, 17'h00000, 1'b1, 1'b1, 8'h11, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 8'h00, 1'b0, 9'h133, 1'b0, 17'h00000, 1'b1, 1'b1, 8'h11, 1'b0};
        vecs[9]  = '{1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b1, 17'h00000, 1'b1, 1'b1, 8'h22, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b1, 17'h00000, 1'b1, 1'b1, 8'h33, 1'b0};
        vecs[11] = '{1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b1, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0};

        model_clear();
        #2;
        chk("rst_flit", flit_out, 17'h0);
        chk("rst_tx_rdy", tx_rdy, 1'b1);
        chk("rst_rx_vld", rx_vld, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_ovf", rx_ovf, 1'b0);
        do_reset();

        // single send then RX burst
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].req, vecs[i].dst, vecs[i].data, vecs[i].ack, vecs[i].dlv, vecs[i].pop);
            chk($sformatf("vec%0d_flit", i), flit_out, vecs[i].e_flit);
            chk($sformatf("vec%0d_rdy", i), tx_rdy, vecs[i].e_rdy);
            chk($sformatf("vec%0d_vld", i), rx_vld, vecs[i].e_vld);
            chk($sformatf("vec%0d_rxd", i), rx_data, vecs[i].e_rxd);
            chk($sformatf("vec%0d_ovf", i), rx_ovf, vecs[i].e_ovf);
        end

        // reset arriving mid-SEND with RX overflowed
        step(1'b1, 4'h9, 8'h5C, 1'b0, 9'h000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 8'h00, 1'b0, 9'h1E0 + 9'(i), 1'b0);
        chk("pre_rst_flit", flit_out, 17'h1925C);
        chk("pre_rst_ovf", rx_ovf, 1'b1);
        tx_req = 1'b0; dlv_in = '0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_flit", flit_out, 17'h0);
        chk("async_rst_rdy", tx_rdy, 1'b1);
        chk("async_rst_vld", rx_vld, 1'b0);
        chk("async_rst_ovf", rx_ovf, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();

        // TX full: one flit goes straight onto the port, four more fill the FIFO
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'(i + 1), 8'h30 + 8'(i), 1'b0, 9'h000, 1'b0);
            if (i == 4) chk("tx_full_rdy", tx_rdy, 1'b0);
        end
        got.delete();
        for (int c = 0; c < 24; c++) begin
            if (flit_out[16]) got.push_back(flit_out[7:0]);
            step(1'b0, 4'h0, 8'h00, flit_out[16], 9'h000, 1'b0);
        end
        chk("tx_full_count", got.size(), 5);
        for (int k = 0; k < got.size(); k++) chk($sformatf("tx_order%0d", k), got[k], 8'h30 + 8'(k));
        chk("tx_drained_rdy", tx_rdy, 1'b1);

        // RX overflow without pop
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 8'h00, 1'b0, 9'h150 + 9'(i), 1'b0);
        chk("rx_ovf_set", rx_ovf, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rx_ovf_data%0d", i), rx_data, 8'h50 + 8'(i));
            step(1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b1);
        end
        chk("rx_ovf_empty", rx_vld, 1'b0);
        chk("rx_ovf_sticky", rx_ovf, 1'b1);

        // RX full with pop on the fifth delivery
        do_reset();
        got.delete();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) got.push_back(rx_data);
            step(1'b0, 4'h0, 8'h00, 1'b0, 9'h150 + 9'(i), i == 4);
        end
        for (int c = 0; c < 8 && rx_vld; c++) begin
            got.push_back(rx_data);
            step(1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b1);
        end
        chk("rx_pop_full_count", got.size(), 5);
        for (int k = 0; k < got.size(); k++) chk($sformatf("rx_pop_full%0d", k), got[k], 8'h50 + 8'(k));
        chk("rx_pop_full_ovf", rx_ovf, 1'b0);

        // push, ack and delivery all in one cycle
        do_reset();
        step(1'b1, 4'h4, 8'h44, 1'b0, 9'h000, 1'b0);
        step(1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b0);
        step(1'b1, 4'h3, 8'h66, 1'b1, 9'h177, 1'b0);
        chk("conc_acked", flit_out, 17'h0);
        chk("conc_rx", rx_data, 8'h77);
        step(1'b0, 4'h0, 8'h00, 1'b0, 9'h000, 1'b1);
        chk("conc_next_flit", flit_out, 17'h13266);
        chk("conc_rx_empty", rx_vld, 1'b0);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 3) != 0, 4'($urandom), 8'($urandom), ($urandom % 2) == 1,
                 {($urandom % 3) != 0, 8'($urandom)}, ($urandom % 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
